// File: rtl/op_issuer.sv
// op_issuer: host command front end for the ALP controller.
// Optional watchdog on T: define OP_ISSUER_TIMEOUT_EN.
module op_issuer #(
  parameter int MAX_T = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_kind,
  input  logic [2:0] cmd_op,
  output logic [2:0] op,
  output logic       comp,
  output logic       load,
  output logic       clr,
  output logic [3:0] T,
  input  logic       clr_SC,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state;
  logic       pend_full;
  logic [1:0] pend_kind;
  logic [2:0] pend_op;

  logic       xfer;
  logic       fill;
  logic       from_slot;
  logic       launch;
  logic [1:0] l_kind;
  logic [2:0] l_op;
  logic       k_comp;
  logic       k_load;
  logic       k_clr;
  logic       clr_hit;
  logic       wd_hit;

  assign cmd_ready = !pend_full;
  assign xfer      = cmd_valid && cmd_ready;

  // Controller's clr_SC is stale on the first RUN cycle.
  assign clr_hit = (T != 4'd0) && clr_SC;

`ifdef OP_ISSUER_TIMEOUT_EN
  assign wd_hit = !clr_hit && (T == 4'(MAX_T));
`else
  logic [3:0] unused_max_t;
  assign unused_max_t = 4'(MAX_T);
  assign wd_hit = 1'b0;
`endif

  // Pick the command to launch: slot first, else host.
  always_comb begin
    from_slot = pend_full &&
                (state == S_IDLE || state == S_DONE);
    launch    = from_slot || (state == S_IDLE && xfer);
    fill      = xfer && (state != S_IDLE);
    l_kind    = from_slot ? pend_kind : cmd_kind;
    l_op      = from_slot ? pend_op : cmd_op;
  end

  // Kind to strobe; reserved kind runs as clear.
  always_comb begin
    k_comp = 1'b0;
    k_load = 1'b0;
    k_clr  = 1'b0;
    unique case (1'b1)
      (l_kind == 2'b00): k_comp = 1'b1;
      (l_kind == 2'b01): k_load = 1'b1;
      default:           k_clr  = 1'b1;
    endcase
  end

  // One-deep pending slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full <= 1'b0;
      pend_kind <= 2'b00;
      pend_op   <= 3'b000;
    end else if (fill) begin
      pend_full <= 1'b1;
      pend_kind <= cmd_kind;
      pend_op   <= cmd_op;
    end else if (from_slot) begin
      pend_full <= 1'b0;
    end
  end

  // Issue FSM: launch, count T, finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op    <= 3'b000;
      comp  <= 1'b0;
      load  <= 1'b0;
      clr   <= 1'b0;
      T     <= 4'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        S_RUN: begin
          if (clr_hit || wd_hit) begin
            state <= S_DONE;
            comp  <= 1'b0;
            load  <= 1'b0;
            clr   <= 1'b0;
            T     <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= wd_hit;
          end else if (T != 4'hF) begin
            T <= T + 4'd1;
          end
        end
        S_DONE: begin
          if (!launch) state <= S_IDLE;
        end
        default: ;
      endcase
      if (launch) begin
        state <= S_RUN;
        op    <= l_op;
        comp  <= k_comp;
        load  <= k_load;
        clr   <= k_clr;
        T     <= 4'd0;
        busy  <= 1'b1;
      end
    end
  end

endmodule
